// File: rtl/ring_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : ring_arbiter_pkg
// Brief  : Shared types and helpers for the one-hot token ring arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package ring_arbiter_pkg;

   // Helper vectors are sized to the widest supported ring; callers zero-pad.
   localparam int c_MAX_N = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [c_MAX_N-1:0] rotl1(input logic [c_MAX_N-1:0] onehot,
                                                 input int                 n);
      logic [c_MAX_N-1:0] r;
      r = '0;
      for (int i = 0; i < c_MAX_N - 1; i++) begin
         if (i + 1 < n) r[i+1] = onehot[i];
      end
      r[0] = onehot[n-1];
      return r;
   endfunction

   function automatic logic [c_MAX_N-1:0] rr_pick(input logic [c_MAX_N-1:0] req,
                                                   input logic [c_MAX_N-1:0] token,
                                                   input int                 n);
      logic [c_MAX_N-1:0] r;
      logic               found;
      int                 t;
      int                 idx;
      r     = '0;
      found = 1'b0;
      t     = 0;
      for (int i = 0; i < c_MAX_N; i++) begin
         if (token[i]) t = i;
      end
      // Search upward from the token position, wrapping at n-1.
      for (int k = 0; k < c_MAX_N; k++) begin
         if (k < n && !found) begin
            idx = t + k;
            if (idx >= n) idx = idx - n;
            if (req[idx]) begin
               r[idx] = 1'b1;
               found  = 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_token.sv
`default_nettype none
// ============================================================================
// Module : ring_token
// Brief  : N-bit one-hot rotating ring register used as the priority pointer.
// Rev    : 1.0  initial release
// ============================================================================
module ring_token
   import ring_arbiter_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         adv,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] token
);

   logic [N-1:0] r_token;
   logic [N-1:0] w_rot;

   always_comb begin
      logic [c_MAX_N-1:0] v_in;
      logic [c_MAX_N-1:0] v_out;
      v_in         = '0;
      v_in[N-1:0]  = r_token;
      v_out        = rotl1(v_in, N);
      w_rot        = v_out[N-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_token <= N'(1);
      end else if (load) begin
         r_token <= load_val;
      end else if (adv) begin
         r_token <= w_rot;
      end
   end

   assign token = r_token;

endmodule
`default_nettype wire

// File: rtl/ring_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ring_arbiter
// Brief  : Round-robin arbiter with one-hot token ring and hold-time preemption.
// Rev    : 1.0  initial release
// ============================================================================
module ring_arbiter
   import ring_arbiter_pkg::*;
#(
   parameter int N        = 3,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 busy,
   output logic                 preempt
);

   localparam int c_IW = $clog2(N);
   // Keep at least one bit so HOLD_MAX = 0 still elaborates cleanly.
   localparam int c_HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
   localparam logic            c_PREEMPT_EN = (HOLD_MAX > 0);

   state_t            r_state;
   state_t            w_state_nx;
   logic [N-1:0]      r_gnt;
   logic [N-1:0]      w_gnt_nx;
   logic [c_IW-1:0]   r_gnt_idx;
   logic [c_IW-1:0]   w_idx_nx;
   logic [c_HW-1:0]   r_hold;
   logic [c_HW-1:0]   w_hold_nx;
   logic              r_busy;
   logic              r_preempt;
   logic              w_preempt_nx;
   logic              w_tok_load;
   logic [N-1:0]      w_tok_nx;
   logic [N-1:0]      w_token;
   logic [N-1:0]      w_pick;
   logic [c_IW-1:0]   w_pick_idx;

   ring_token #(.N(N)) u_token (
      .clk      (clk),
      .rst      (reset),
      .adv      (1'b0),
      .load     (w_tok_load),
      .load_val (w_tok_nx),
      .token    (w_token)
   );

   always_comb begin
      logic [c_MAX_N-1:0] v_req;
      logic [c_MAX_N-1:0] v_tok;
      logic [c_MAX_N-1:0] v_gnt;
      logic [c_MAX_N-1:0] v_pick;
      logic [c_MAX_N-1:0] v_rot;
      v_req         = '0;
      v_tok         = '0;
      v_gnt         = '0;
      v_req[N-1:0]  = req;
      v_tok[N-1:0]  = w_token;
      v_gnt[N-1:0]  = r_gnt;
      v_pick        = rr_pick(v_req, v_tok, N);
      v_rot         = rotl1(v_gnt, N);
      w_pick        = v_pick[N-1:0];
      w_tok_nx      = v_rot[N-1:0];
      w_pick_idx    = '0;
      for (int i = 0; i < N; i++) begin
         if (w_pick[i]) w_pick_idx = c_IW'(i);
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_gnt_nx     = r_gnt;
      w_idx_nx     = r_gnt_idx;
      w_hold_nx    = r_hold;
      w_preempt_nx = 1'b0;
      w_tok_load   = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_gnt_nx   = w_pick;
               w_idx_nx   = w_pick_idx;
               w_hold_nx  = '0;
               w_state_nx = GRANT;
            end
         end
         GRANT: begin
            if (!(|(req & r_gnt))) begin
               w_gnt_nx   = '0;
               w_idx_nx   = '0;
               w_tok_load = 1'b1;
               w_state_nx = IDLE;
            end else if (c_PREEMPT_EN && (r_hold == c_HOLD_LAST)) begin
               w_gnt_nx     = '0;
               w_idx_nx     = '0;
               w_tok_load   = 1'b1;
               w_preempt_nx = 1'b1;
               w_state_nx   = IDLE;
            end else if (r_hold != c_HOLD_LAST) begin
               w_hold_nx = r_hold + c_HW'(1);
            end
         end
         default: begin
            w_gnt_nx   = '0;
            w_idx_nx   = '0;
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_hold    <= '0;
         r_busy    <= 1'b0;
         r_preempt <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_gnt     <= w_gnt_nx;
         r_gnt_idx <= w_idx_nx;
         r_hold    <= w_hold_nx;
         r_busy    <= |w_gnt_nx;
         r_preempt <= w_preempt_nx;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_idx = r_gnt_idx;
   assign busy    = r_busy;
   assign preempt = r_preempt;

endmodule
`default_nettype wire
